// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Integer register file with a pending-write scoreboard.
//   - NRD combinational read ports, each returning data plus a pending flag.
//   - Execute write port (i_wen) and late-return load port (i_lwen). The load
//     port also clears the pending bit of its target.
//   - Reserve port (i_rsv_en) sets the pending bit of an entry.
//   - Entry 0 is constant zero and never pending.
//   - After reset the array and scoreboard are cleared one entry per cycle.
//     o_ready rises when the clear is done. Until then, writes and reserves
//     are dropped and reads return zero with busy low.
//
// Ports
//   i_clk, i_rst                  clock, synchronous active-high reset
//   o_ready                       clear sequence finished
//   i_raddr[NRD*AW] / o_rdata[NRD*XLEN] / o_rbusy[NRD]  read ports
//   i_wen, i_waddr, i_wdata       execute write port
//   i_lwen, i_lwaddr, i_lwdata    late-return write port (clears pending bit)
//   i_rsv_en, i_rsv_addr          reserve port (sets pending bit)
//   o_waw                         one-cycle pulse: i_wen hit a pending entry
//
// Valid/ready: there is no backpressure. Every enable is a single-cycle
// command that is accepted on the rising edge when o_ready is high, and is
// dropped when o_ready is low.
//
// Configuration macro: REGFILE_SB_BYPASS_EN
//   defined   - same-cycle write data (load port first, then execute port)
//               is forwarded to matching reads. A same-cycle load return
//               also forces the read's busy flag low, unless a same-cycle
//               reserve targets that entry too.
//   undefined - reads see stored contents only.
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_ready,
    input  logic [NRD*AW-1:0]   i_raddr,
    output logic [NRD*XLEN-1:0] o_rdata,
    output logic [NRD-1:0]      o_rbusy,
    input  logic                i_wen,
    input  logic [AW-1:0]       i_waddr,
    input  logic [XLEN-1:0]     i_wdata,
    input  logic                i_lwen,
    input  logic [AW-1:0]       i_lwaddr,
    input  logic [XLEN-1:0]     i_lwdata,
    input  logic                i_rsv_en,
    input  logic [AW-1:0]       i_rsv_addr,
    output logic                o_waw
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [XLEN-1:0]   mem_q [NREGS];
    logic [XLEN-1:0]   mem_d [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;
    logic              waw_q, waw_d;

    // Write qualifiers: index 0 is never a real target.
    logic wr_ex, wr_ld, wr_rsv;
    assign wr_ex  = i_wen    && (i_waddr    != '0);
    assign wr_ld  = i_lwen   && (i_lwaddr   != '0);
    assign wr_rsv = i_rsv_en && (i_rsv_addr != '0);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_d     = mem_q;
        pend_d    = pend_q;
        waw_d     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_d[clr_idx_q]  = '0;
                pend_d[clr_idx_q] = 1'b0;
                clr_idx_d         = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Load port is applied last so it wins a same-index conflict.
                if (wr_ex) begin
                    mem_d[i_waddr] = i_wdata;
                end
                if (wr_ld) begin
                    mem_d[i_lwaddr]  = i_lwdata;
                    pend_d[i_lwaddr] = 1'b0;
                end
                // Reserve is applied after the load clear so it wins.
                if (wr_rsv) begin
                    pend_d[i_rsv_addr] = 1'b1;
                end
                // Hazard judged on the pending bit as it stands at this edge.
                waw_d = wr_ex && pend_q[i_waddr] &&
                        !(wr_ld && (i_lwaddr == i_waddr));
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_idx_d = AW'(1);
            end
        endcase
        mem_d[0]  = '0;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= AW'(1);
            waw_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            waw_q     <= waw_d;
        end
    end

    // Array and scoreboard are not reset directly: the clear sequence wipes
    // them, and reads are masked until it completes.
    always_ff @(posedge i_clk) begin
        mem_q  <= mem_d;
        pend_q <= pend_d;
    end

    assign o_ready = (state_q == ST_RUN);
    assign o_waw   = waw_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = i_raddr[k*AW +: AW];

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if ((state_q == ST_RUN) && (ra != '0)) begin
                rd = mem_q[ra];
                rb = pend_q[ra];
`ifdef REGFILE_SB_BYPASS_EN
                if (i_lwen && (i_lwaddr == ra)) begin
                    rd = i_lwdata;
                    if (!(i_rsv_en && (i_rsv_addr == ra))) begin
                        rb = 1'b0;
                    end
                end else if (i_wen && (i_waddr == ra)) begin
                    rd = i_wdata;
                end
`endif
            end
        end

        assign o_rdata[k*XLEN +: XLEN] = rd;
        assign o_rbusy[k]              = rb;
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
  localparam int W     = 64;

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic                o_ready;
  logic [NRD*AW-1:0]   i_raddr;
  logic [NRD*XLEN-1:0] o_rdata;
  logic [NRD-1:0]      o_rbusy;
  logic                i_wen, i_lwen, i_rsv_en;
  logic [AW-1:0]       i_waddr, i_lwaddr, i_rsv_addr;
  logic [XLEN-1:0]     i_wdata, i_lwdata;
  logic                o_waw;

  logic [AW-1:0] rad [NRD];
  assign i_raddr = {rad[1], rad[0]};

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_ready(o_ready),
    .i_raddr(i_raddr), .o_rdata(o_rdata), .o_rbusy(o_rbusy),
    .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata),
    .i_lwen(i_lwen), .i_lwaddr(i_lwaddr), .i_lwdata(i_lwdata),
    .i_rsv_en(i_rsv_en), .i_rsv_addr(i_rsv_addr), .o_waw(o_waw)
  );

  // clock / reset block
  always #5 i_clk = ~i_clk;

  // scoreboard
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    logic [W-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    total++;
    if (obs !== e) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // reference model: architectural register contents and pending set
  logic [XLEN-1:0] m_mem [NREGS];
  logic [NREGS-1:0] m_pend;
  logic m_ready;
  logic m_waw;
  int   m_clr;

  task automatic idle();
    i_wen = 0; i_waddr = 0; i_wdata = 0;
    i_lwen = 0; i_lwaddr = 0; i_lwdata = 0;
    i_rsv_en = 0; i_rsv_addr = 0;
  endtask

  task automatic check_all();
    logic [XLEN-1:0] e_d;
    logic e_b;
    for (int k = 0; k < NRD; k++) begin
      e_d = '0;
      e_b = 1'b0;
      if (m_ready && rad[k] != 0) begin
        e_d = m_mem[rad[k]];
        e_b = m_pend[rad[k]];
`ifdef REGFILE_SB_BYPASS_EN
        if (i_lwen && i_lwaddr == rad[k]) begin
          e_d = i_lwdata;
          if (!(i_rsv_en && i_rsv_addr == rad[k])) e_b = 1'b0;
        end else if (i_wen && i_waddr == rad[k]) begin
          e_d = i_wdata;
        end
`endif
      end
      check("model_rdata", o_rdata[k*XLEN +: XLEN], e_d);
      check("model_rbusy", o_rbusy[k], e_b);
    end
    check("model_ready", o_ready, m_ready);
    check("model_waw", o_waw, m_waw);
  endtask

  task automatic tick();
    logic n_waw;
    n_waw = 1'b0;
    if (i_rst) begin
      m_ready = 1'b0;
      m_clr   = 1;
    end else if (!m_ready) begin
      m_mem[m_clr] = '0;
      m_pend[m_clr] = 1'b0;
      if (m_clr == NREGS - 1) m_ready = 1'b1;
      m_clr++;
    end else begin
      n_waw = i_wen && i_waddr != 0 && m_pend[i_waddr] &&
              !(i_lwen && i_lwaddr == i_waddr);
      if (i_wen && i_waddr != 0) m_mem[i_waddr] = i_wdata;
      if (i_lwen && i_lwaddr != 0) begin
        m_mem[i_lwaddr] = i_lwdata;
        m_pend[i_lwaddr] = 1'b0;
      end
      if (i_rsv_en && i_rsv_addr != 0) m_pend[i_rsv_addr] = 1'b1;
    end
    @(posedge i_clk);
    #1;
    m_waw = n_waw;
  endtask

  task automatic step();
    #1;
    check_all();
    tick();
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (o_ready !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  int cnt;
  logic [XLEN-1:0] exp_byp;

  initial begin
    for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
    m_pend = '0; m_ready = 1'b0; m_waw = 1'b0; m_clr = 1;
    rad[0] = 0; rad[1] = 0;
    idle();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    check("reset_ready", o_ready, 1'b0);
    check("reset_waw", o_waw, 1'b0);

    i_wen = 1; i_waddr = 5; i_wdata = 32'h77;
    wait_ready(cnt);
    check("clear_len", cnt, 31);
    idle();
    rad[0] = 5;
    #1;
    check("clear_write_lost", o_rdata[31:0], 32'h0);

    i_wen = 1; i_waddr = 5; i_wdata = 32'hDEADBEEF;
    step();
    i_waddr = 0; i_wdata = 32'h1;
    step();
    idle();
    rad[0] = 5; rad[1] = 0;
    #1;
    check("x5_read", o_rdata[31:0], 32'hDEADBEEF);
    check("x0_read", o_rdata[63:32], 32'h0);

    i_rsv_en = 1; i_rsv_addr = 7;
    step();
    idle();
    rad[0] = 7;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("x7_busy_wait", o_rbusy[0], 1'b1);
      step();
    end
    i_lwen = 1; i_lwaddr = 7; i_lwdata = 32'h12345678;
    step();
    idle();
    #1;
    check("x7_busy_after", o_rbusy[0], 1'b0);
    check("x7_data", o_rdata[31:0], 32'h12345678);
    i_rsv_en = 1; i_rsv_addr = 7;
    i_lwen = 1; i_lwaddr = 7; i_lwdata = 32'h9;
    step();
    idle();
    #1;
    check("x7_rsv_wins", o_rbusy[0], 1'b1);
    i_lwen = 1; i_lwaddr = 7; i_lwdata = 32'h9;
    step();
    idle();

    i_wen = 1; i_waddr = 9; i_wdata = 32'hAAAA;
    i_lwen = 1; i_lwaddr = 9; i_lwdata = 32'h5555;
    step();
    idle();
    rad[0] = 9;
    #1;
    check("x9_conflict", o_rdata[31:0], 32'h5555);

    i_rsv_en = 1; i_rsv_addr = 3;
    step();
    idle();
    i_wen = 1; i_waddr = 3; i_wdata = 32'h10;
    step();
    idle();
    rad[0] = 3;
    #1;
    check("waw_pulse", o_waw, 1'b1);
    check("x3_data", o_rdata[31:0], 32'h10);
    check("x3_busy", o_rbusy[0], 1'b1);
    step();
    #1;
    check("waw_one_cycle", o_waw, 1'b0);

    i_wen = 1; i_waddr = 4; i_wdata = 32'h1111;
    step();
    i_wdata = 32'hCAFE;
    rad[1] = 4;
`ifdef REGFILE_SB_BYPASS_EN
    exp_byp = 32'hCAFE;
`else
    exp_byp = 32'h1111;
`endif
    #1;
    check("bypass_read", o_rdata[63:32], exp_byp);
    step();
    idle();

    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_wen = 1; i_waddr = 9; i_wdata = 32'hBEEF;
    wait_ready(cnt);
    check("reclear_len", cnt, 31);
    idle();
    for (int r = 0; r < NREGS; r += 2) begin
      rad[0] = AW'(r); rad[1] = AW'(r + 1);
      #1;
      check("cleared_data0", o_rdata[31:0], 32'h0);
      check("cleared_data1", o_rdata[63:32], 32'h0);
      check("cleared_busy", o_rbusy, 2'b00);
    end

    for (int i = 0; i < 400; i++) begin
      i_rst      = ($urandom_range(0, 199) == 0);
      i_wen      = $urandom_range(0, 1);
      i_waddr    = AW'($urandom_range(0, 15));
      i_wdata    = $urandom;
      i_lwen     = $urandom_range(0, 1);
      i_lwaddr   = AW'($urandom_range(0, 15));
      i_lwdata   = $urandom;
      i_rsv_en   = $urandom_range(0, 1);
      i_rsv_addr = AW'($urandom_range(0, 15));
      rad[0]     = AW'($urandom_range(0, 15));
      rad[1]     = AW'($urandom_range(0, 15));
      step();
    end
    i_rst = 1'b0;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a pending-write scoreboard for the next-generation multi-cycle core. It provides NRD asynchronous read ports and two synchronous write ports: an execute port, and a late-return port for loads that complete out of order. Entry 0 is hardwired to zero. After reset the block runs a sequential clear of the array and reports readiness before accepting writes.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of entries, power of two, at least 4; entry 0 is constant zero.
- NRD, 2: number of read ports.
- AW, $clog2(NREGS): index width (derived; do not override).
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- o_ready  out  1  high once the clear sequence is done; reset value 0.
- i_raddr  in  NRD*AW  packed read indices; port k uses bits [k*AW +: AW].
- o_rdata  out  NRD*XLEN  packed read data, combinational.
- o_rbusy  out  NRD  per-port pending flag for the addressed entry, combinational.
- i_wen, i_waddr (AW), i_wdata (XLEN)  in  execute write port.
- i_lwen, i_lwaddr (AW), i_lwdata (XLEN)  in  late-return (load) write port; also clears the pending bit.
- i_rsv_en, i_rsv_addr (AW)  in  reserve an entry: set its pending bit.
- o_waw  out  1  registered one-cycle pulse; reset value 0.

## Operation
- FSM states:
  - CLEAR: entered on i_rst. A counter clr_idx starts at 1. Each cycle the block writes 0 to entry clr_idx and clears its pending bit, then increments clr_idx. When clr_idx == NREGS-1 is written, the next state is RUN.
  - RUN: o_ready = 1.
- i_rst asserted in any state, including mid-CLEAR, restarts CLEAR at clr_idx = 1.
- In CLEAR, all write and reserve inputs are ignored, o_rdata reads 0 and o_rbusy reads 0.
- Read: port k returns entry i_raddr[k]. Index 0 always returns 0 with busy 0.
- Write port rules, in RUN:
  - A write to index 0 has no effect on any port, and a reserve of index 0 is ignored.
  - If i_wen and i_lwen target the same index in the same cycle, i_lwdata is written.
- Pending bit update for index n, applied in priority order:
  - i_rsv_en to n sets the bit; this wins over a same-cycle i_lwen to n.
  - Otherwise i_lwen to n clears the bit.
- o_waw pulses the cycle after an i_wen whose target is pending at that edge and is not simultaneously cleared by i_lwen. The write still lands. Hazard ordering is the issuer's responsibility; o_waw is diagnostic only.
- i_lwen to an entry that is not pending still writes the data. No error is raised.

## Timing
- A write or reserve takes effect at the rising edge and is visible on o_rdata/o_rbusy in the following cycle (bypass behaviour is covered under Configuration).
- Clear latency: after i_rst deasserts, o_ready rises exactly NREGS-1 cycles later. For NREGS=32, that is 31 cycles.
- The read path has no pipeline. Write-to-read latency is 1 edge.

## Configuration
- REGFILE_SB_BYPASS_EN defined:
  - In RUN, a read whose index matches a same-cycle write (load port first, then execute port) returns the write data combinationally.
  - o_rbusy is forced to 0 when i_lwen targets that index in the same cycle, unless i_rsv_en also targets it.
- REGFILE_SB_BYPASS_EN undefined: reads return stored array contents only, with 1-cycle visibility.

## Test plan
- Reset clear: preload entries via RUN writes, assert i_rst for 1 cycle, then release. Required: o_ready is 0 for 31 cycles then 1, all reads return 0, and writes issued during CLEAR are lost. Re-asserting i_rst at clear cycle 10 must yield another full 31-cycle clear.
- Basic write/read: write 0xDEADBEEF to x5 and 0x1 to x0. Required: port 0 reads x5 = 0xDEADBEEF the next cycle, and x0 reads 0.
- Scoreboard: reserve x7, then 4 cycles later send i_lwen to x7 with 0x12345678. Required: o_rbusy for x7 is 1 throughout the wait and 0 after the return edge, with data 0x12345678. A reserve plus lwen on x7 in the same cycle must leave it busy.
- Port conflict: i_wen x9 = 0xAAAA and i_lwen x9 = 0x5555 in the same cycle. Required: x9 reads 0x5555.
- WAW: reserve x3, then i_wen x3 = 0x10. Required: o_waw high for exactly 1 cycle, x3 = 0x10, and x3 still busy.
- Bypass (macro on): i_wen x4 = 0xCAFE with port 1 reading x4 in the same cycle. Required: 0xCAFE same cycle. With the macro off, port 1 shows the old value that cycle.
